axi_rd_arbiter: RTL and testbench

Read-channel arbiter sharing the single AXI3 AR/R port of the CPU top between the instruction-fetch path and the data path of the MMU/cache layer. Accepts one burst request per requester, selects a winner, drives the AR channel, and routes returned R beats to the owner. Exactly one read transaction is outstanding at a time. Sits between the cache refill/uncached read logic and the external AXI interface; the write channels are outside its scope.

---
 rtl/axi_rd_arbiter.sv | 114 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 AR/R port between inst and data readers; AXI_RD_ARB_RR_EN selects round-robin over fixed data priority
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  input  logic [2:0]  inst_size,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  output logic        inst_rerr,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [7:0]  data_len,
  input  logic [2:0]  data_size,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  output logic        data_rerr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic own_data, win_data, beat, err;
  logic [7:0] cnt;
`ifdef AXI_RD_ARB_RR_EN
  logic last_inst;
  assign win_data = data_req & (!inst_req | last_inst);
`else
  assign win_data = data_req;
`endif
  assign beat = rvalid & rready;
  assign err = (rresp != 2'b00) || (rid != arid) || (rlast && cnt != arlen) || (cnt == arlen && !rlast);
  assign inst_gnt = arvalid & arready & !own_data;
  assign data_gnt = arvalid & arready & own_data;
  assign inst_rvalid = beat & !own_data;
  assign data_rvalid = beat & own_data;
  assign inst_rlast = inst_rvalid & rlast;
  assign data_rlast = data_rvalid & rlast;
  assign inst_rerr = inst_rvalid & err;
  assign data_rerr = data_rvalid & err;
  assign inst_rdata = rdata;
  assign data_rdata = rdata;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own_data <= 1'b0;
      cnt <= 8'd0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      arid <= 4'd0;
      araddr <= 32'd0;
      arlen <= 8'd0;
      arsize <= 3'd0;
`ifdef AXI_RD_ARB_RR_EN
      last_inst <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (inst_req || data_req) begin
          state <= ADDR;
          own_data <= win_data;
          arid <= win_data ? DATA_ID : INST_ID;
          araddr <= win_data ? data_addr : inst_addr;
          arlen <= win_data ? data_len : inst_len;
          arsize <= win_data ? data_size : inst_size;
          cnt <= 8'd0;
          arvalid <= 1'b1;
        end
        ADDR: if (arready) begin
          state <= DATA;
          arvalid <= 1'b0;
          rready <= 1'b1;
`ifdef AXI_RD_ARB_RR_EN
          last_inst <= !own_data;
`endif
        end
        DATA: if (rvalid) begin
          cnt <= cnt + 8'd1;
          if (rlast) begin
            state <= IDLE;
            rready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_req = 0, data_req = 0;
  logic [31:0] inst_addr = 0, data_addr = 0;
  logic [7:0] inst_len = 0, data_len = 0;
  logic [2:0] inst_size = 0, data_size = 0;
  logic inst_gnt, inst_rvalid, inst_rlast, inst_rerr;
  logic data_gnt, data_rvalid, data_rlast, data_rerr;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0] arid, arcache;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  logic arvalid, arready = 0;
  logic [3:0] rid = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0;
  logic rlast = 0, rvalid = 0, rready;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len), .inst_size(inst_size),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rlast(inst_rlast), .inst_rerr(inst_rerr),
    .data_req(data_req), .data_addr(data_addr), .data_len(data_len), .data_size(data_size),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_rlast(data_rlast), .data_rerr(data_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  task automatic start(input bit d, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    @(negedge clk);
    if (d) begin data_req = 1; data_addr = a; data_len = l; data_size = s; end
    else begin inst_req = 1; inst_addr = a; inst_len = l; inst_size = s; end
    arready = 1;
    @(negedge clk);
    @(negedge clk);
    inst_req = 0; data_req = 0; arready = 0;
  endtask
  task automatic drive_beat(input logic [3:0] i, input logic [31:0] d, input logic l, input logic [1:0] r);
    rvalid = 1; rid = i; rdata = d; rlast = l; rresp = r;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL reset_rready got %b want 0", rready); end
    n_cmp++; if ({arid, araddr, arlen, arsize} !== 47'd0) begin n_err++; $display("FAIL reset_ar_fields got %h/%h/%h/%h want 0", arid, araddr, arlen, arsize); end
    n_cmp++; if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid, inst_rlast, data_rlast, inst_rerr, data_rerr} !== 8'd0) begin n_err++; $display("FAIL reset_side_outputs got nonzero want 0"); end
    n_cmp++; if ({arburst, arlock, arcache, arprot} !== 11'b01_00_0000_000) begin n_err++; $display("FAIL reset_ar_consts got %b %b %h %h want 01 00 0 0", arburst, arlock, arcache, arprot); end
    rst = 0;
  endtask
  task automatic test_single_inst;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1FC0_0000; inst_len = 8'd7; inst_size = 3'd2; arready = 1;
    #1;
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_early got %b want 0", arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid got %b want 1", arvalid); end
    n_cmp++; if ({arid, arlen, arsize} !== {4'd0, 8'd7, 3'd2}) begin n_err++; $display("FAIL single_ar_fields got id %h len %h size %h want 0 7 2", arid, arlen, arsize); end
    n_cmp++; if (araddr !== 32'h1FC0_0000) begin n_err++; $display("FAIL single_araddr got %h want 1fc00000", araddr); end
    n_cmp++; if ({inst_gnt, data_gnt} !== 2'b10) begin n_err++; $display("FAIL single_gnt got %b want 10", {inst_gnt, data_gnt}); end
    @(negedge clk);
    inst_req = 0; arready = 0;
    #1;
    n_cmp++; if ({rready, arvalid, inst_gnt} !== 3'b100) begin n_err++; $display("FAIL single_data_state got %b want 100", {rready, arvalid, inst_gnt}); end
    for (int i = 0; i < 8; i++) begin
      drive_beat(4'd0, 32'hA000_0000 + i, i == 7, 2'b00);
      #1;
      n_cmp++; if ({inst_rvalid, data_rvalid, inst_rlast, inst_rerr} !== {1'b1, 1'b0, i == 7, 1'b0}) begin n_err++; $display("FAIL single_beat%0d got %b want 10%b0", i, {inst_rvalid, data_rvalid, inst_rlast, inst_rerr}, i == 7); end
      n_cmp++; if (inst_rdata !== 32'hA000_0000 + i) begin n_err++; $display("FAIL single_rdata%0d got %h want %h", i, inst_rdata, 32'hA000_0000 + i); end
      @(negedge clk);
    end
    rvalid = 0; rlast = 0;
    #1;
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL single_idle_rready got %b want 0", rready); end
  endtask
  task automatic test_arbitration;
    bit found;
`ifdef AXI_RD_ARB_RR_EN
    logic exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit rr = 1;
`else
    logic exp [2] = '{1'b1, 1'b0};
    bit rr = 0;
`endif
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; inst_len = 0; data_len = 0; arready = 1;
    for (int k = 0; k < $size(exp); k++) begin
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk); #1;
        found = arvalid;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL arb_timeout%0d got no arvalid want arvalid within 10 cycles", k); end
      n_cmp++; if (arid !== (exp[k] ? 4'd1 : 4'd0)) begin n_err++; $display("FAIL arb_arid%0d got %h want %h", k, arid, exp[k] ? 4'd1 : 4'd0); end
      n_cmp++; if ({data_gnt, inst_gnt} !== (exp[k] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL arb_gnt%0d got %b want %b", k, {data_gnt, inst_gnt}, exp[k] ? 2'b10 : 2'b01); end
      @(negedge clk);
      if (k == $size(exp) - 1) begin inst_req = 0; data_req = 0; arready = 0; end
      else if (!rr && exp[k]) data_req = 0;
      drive_beat(exp[k] ? 4'd1 : 4'd0, 32'h55, 1'b1, 2'b00);
      #1;
      n_cmp++; if ({data_rvalid, inst_rvalid, data_rerr | inst_rerr} !== {exp[k], !exp[k], 1'b0}) begin n_err++; $display("FAIL arb_beat%0d got %b want %b", k, {data_rvalid, inst_rvalid, data_rerr | inst_rerr}, {exp[k], !exp[k], 1'b0}); end
      @(negedge clk);
      rvalid = 0; rlast = 0;
    end
  endtask
  task automatic test_ar_stall;
    @(negedge clk);
    data_req = 1; data_addr = 32'h8000_1230; data_len = 8'd0; data_size = 3'd2; arready = 0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if ({arvalid, data_gnt, inst_gnt} !== 3'b100 || araddr !== 32'h8000_1230 || arlen !== 8'd0 || arid !== 4'd1) begin n_err++; $display("FAIL stall_c%0d got v%b g%b a%h l%h id%h want v1 g0 a80001230 l0 id1", c, arvalid, data_gnt, araddr, arlen, arid); end
      @(negedge clk);
    end
    arready = 1;
    #1;
    n_cmp++; if ({data_gnt, inst_gnt} !== 2'b10) begin n_err++; $display("FAIL stall_gnt got %b want 10", {data_gnt, inst_gnt}); end
    @(negedge clk);
    data_req = 0; arready = 0;
    #1;
    n_cmp++; if ({data_gnt, arvalid, rready} !== 3'b001) begin n_err++; $display("FAIL stall_after got %b want 001", {data_gnt, arvalid, rready}); end
    drive_beat(4'd1, 32'h77, 1'b1, 2'b00);
    @(negedge clk);
    rvalid = 0; rlast = 0;
  endtask
  task automatic test_rresp_err;
    start(1'b1, 32'h0000_4000, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) begin
      drive_beat(4'd1, i, i == 3, i == 1 ? 2'b10 : 2'b00);
      #1;
      n_cmp++; if ({data_rvalid, data_rerr, data_rlast} !== {1'b1, i == 1, i == 3}) begin n_err++; $display("FAIL rresp_beat%0d got %b want 1%b%b", i, {data_rvalid, data_rerr, data_rlast}, i == 1, i == 3); end
      @(negedge clk);
    end
    rvalid = 0; rlast = 0; rresp = 0;
    #1;
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL rresp_idle got rready %b want 0", rready); end
  endtask
  task automatic test_early_rlast;
    start(1'b1, 32'h0000_5000, 8'd3, 3'd2);
    drive_beat(4'd1, 32'h1, 1'b0, 2'b00);
    #1;
    n_cmp++; if ({data_rvalid, data_rerr} !== 2'b10) begin n_err++; $display("FAIL early_beat0 got %b want 10", {data_rvalid, data_rerr}); end
    @(negedge clk);
    drive_beat(4'd1, 32'h2, 1'b1, 2'b00);
    #1;
    n_cmp++; if ({data_rvalid, data_rerr, data_rlast} !== 3'b111) begin n_err++; $display("FAIL early_beat1 got %b want 111", {data_rvalid, data_rerr, data_rlast}); end
    @(negedge clk);
    rvalid = 0; rlast = 0;
    #1;
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL early_idle got rready %b want 0", rready); end
  endtask
  task automatic test_reset_mid;
    start(1'b0, 32'h0000_6000, 8'd7, 3'd2);
    for (int i = 0; i < 2; i++) begin
      drive_beat(4'd0, i, 1'b0, 2'b00);
      @(negedge clk);
    end
    rvalid = 0; rst = 1;
    @(negedge clk); #1;
    n_cmp++; if ({arvalid, rready} !== 2'b00 || araddr !== 32'd0 || arlen !== 8'd0 || arid !== 4'd0) begin n_err++; $display("FAIL rstmid_outputs got v%b r%b a%h l%h id%h want all 0", arvalid, rready, araddr, arlen, arid); end
    rst = 0;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h0000_7000; inst_len = 8'd0; arready = 1;
    #1;
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_arvalid_early got %b want 0", arvalid); end
    @(negedge clk); #1;
    n_cmp++; if ({arvalid, inst_gnt, arid} !== {2'b11, 4'd0} || araddr !== 32'h0000_7000) begin n_err++; $display("FAIL rstmid_ar got v%b g%b id%h a%h want 1 1 0 00007000", arvalid, inst_gnt, arid, araddr); end
    @(negedge clk);
    inst_req = 0; arready = 0;
    drive_beat(4'd0, 32'hBEEF, 1'b1, 2'b00);
    #1;
    n_cmp++; if ({inst_rvalid, inst_rlast, inst_rerr} !== 3'b110 || inst_rdata !== 32'hBEEF) begin n_err++; $display("FAIL rstmid_beat got %b d%h want 110 dbeef", {inst_rvalid, inst_rlast, inst_rerr}, inst_rdata); end
    @(negedge clk);
    rvalid = 0; rlast = 0;
  endtask
  initial begin
    test_reset();
    test_single_inst();
    test_arbitration();
    test_ar_stall();
    test_rresp_err();
    test_early_rlast();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
